card_select_collector: RTL and testbench

//  Upstream stage of the card-clear datapath in the 3x3 matching game.
//  - Collects three distinct player picks (card 1..9) from switches + key.
//  - Checks whether the three cards carry the same symbol.
//  - On a match, presents the packed triple to the clear datapath and holds a

---
 rtl/card_select_collector.sv | 164 ++++++++++++++++
 tb/tb_card_select_collector.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/card_select_collector.sv
// Collects three distinct card picks, checks them for a common symbol and hands a
// matching triple to the clear datapath; tracks removed cards, score and game end.
module card_select_collector #(
    parameter int MISS_HOLD = 25_000_000,
    parameter int SCORE_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         sel_card,
    input  logic               sel_go,
    input  logic [35:0]        card_syms,
    input  logic               clear_done,
    output logic [11:0]        sel_word,
    output logic               clear_req,
    output logic [1:0]         pick_count,
    output logic               bad_pick,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic               all_clear
);

    localparam int CNT_W = $clog2(MISS_HOLD + 1);
    localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_HOLD - 1);

    typedef enum logic [2:0] {
        S_PICK1, S_PICK2, S_PICK3, S_CHECK, S_CLEAR, S_MISS
    } state_t;

    state_t             state, state_nx;
    logic               go_q;
    logic [11:0]        word_q, word_nx;
    logic [8:0]         removed, removed_nx;
    logic [SCORE_W-1:0] score_q, score_nx;
    logic               all_clear_q, all_clear_nx;
    logic               bad_q, bad_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;

    logic               pick_ev;
    logic               card_ok;
    logic               is_removed;
    logic [8:0]         triple_mask;

    function automatic logic [3:0] sym_of(input logic [35:0] syms, input logic [3:0] c);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 0; i < 9; i++)
            if (c == 4'(i + 1)) r = syms[4*i +: 4];
        return r;
    endfunction

    assign pick_ev = sel_go & ~go_q;

    always_comb begin
        is_removed  = 1'b0;
        triple_mask = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (sel_card == 4'(i + 1) && removed[i]) is_removed = 1'b1;
            triple_mask[i] = (word_q[3:0] == 4'(i + 1)) || (word_q[7:4] == 4'(i + 1)) ||
                             (word_q[11:8] == 4'(i + 1));
        end
        // Unheld slots read as 0, and card 0 is already rejected, so all three compare safely.
        card_ok = (sel_card >= 4'd1) && (sel_card <= 4'd9) && !is_removed &&
                  (sel_card != word_q[3:0]) && (sel_card != word_q[7:4]) &&
                  (sel_card != word_q[11:8]);
    end

    always_comb begin
        state_nx     = state;
        word_nx      = word_q;
        removed_nx   = removed;
        score_nx     = score_q;
        all_clear_nx = all_clear_q;
        bad_nx       = 1'b0;
        cnt_nx       = cnt;
        case (state)
            S_PICK1, S_PICK2, S_PICK3: begin
                if (pick_ev && !all_clear_q) begin
                    if (!card_ok) begin
                        bad_nx = 1'b1;
                    end else if (state == S_PICK1) begin
                        word_nx[3:0] = sel_card;
                        state_nx     = S_PICK2;
                    end else if (state == S_PICK2) begin
                        word_nx[7:4] = sel_card;
                        state_nx     = S_PICK3;
                    end else begin
                        word_nx[11:8] = sel_card;
                        state_nx      = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (sym_of(card_syms, word_q[3:0]) == sym_of(card_syms, word_q[7:4]) &&
                    sym_of(card_syms, word_q[3:0]) == sym_of(card_syms, word_q[11:8])) begin
                    state_nx = S_CLEAR;
                end else begin
                    state_nx = S_MISS;
                    cnt_nx   = '0;
                end
            end
            S_CLEAR: begin
                if (clear_done) begin
                    removed_nx   = removed | triple_mask;
                    score_nx     = score_q + SCORE_W'(1);
                    all_clear_nx = all_clear_q | (removed_nx == 9'h1FF);
                    word_nx      = '0;
                    state_nx     = S_PICK1;
                end
            end
            S_MISS: begin
                if (cnt == MISS_LAST) begin
                    word_nx  = '0;
                    state_nx = S_PICK1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                word_nx  = '0;
                state_nx = S_PICK1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_PICK1;
            go_q        <= 1'b0;
            word_q      <= '0;
            removed     <= '0;
            score_q     <= '0;
            all_clear_q <= 1'b0;
            bad_q       <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_nx;
            go_q        <= sel_go;
            word_q      <= word_nx;
            removed     <= removed_nx;
            score_q     <= score_nx;
            all_clear_q <= all_clear_nx;
            bad_q       <= bad_nx;
            cnt         <= cnt_nx;
        end
    end

    always_comb begin
        case (state)
            S_PICK1:                  pick_count = 2'd0;
            S_PICK2:                  pick_count = 2'd1;
            S_PICK3:                  pick_count = 2'd2;
            S_CHECK, S_CLEAR, S_MISS: pick_count = 2'd3;
            default:                  pick_count = 2'd0;
        endcase
    end

    assign sel_word  = word_q;
    assign clear_req = (state == S_CLEAR);
    assign miss      = (state == S_MISS);
    assign bad_pick  = bad_q;
    assign score     = score_q;
    assign all_clear = all_clear_q;

endmodule

// File: tb/tb_card_select_collector.sv
// Scenario bench for card_select_collector: matching triples are queued on the
// third pick and checked when clear_req appears.
module tb_card_select_collector;

    localparam logic [35:0] GAME1 = 36'hA654A321A; // 1,5,9 = A, others distinct
    localparam logic [35:0] GAME2 = 36'hACBBACCBA; // {1,5,9}=A {2,6,7}=B {3,4,8}=C

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  sel_card = '0;
    logic        sel_go = 1'b0;
    logic [35:0] card_syms = GAME1;
    logic        clear_done = 1'b0;
    logic [11:0] sel_word;
    logic        clear_req;
    logic [1:0]  pick_count;
    logic        bad_pick;
    logic        miss;
    logic [3:0]  score;
    logic        all_clear;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_w;

    card_select_collector #(.MISS_HOLD(4), .SCORE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .sel_card(sel_card), .sel_go(sel_go),
        .card_syms(card_syms), .clear_done(clear_done), .sel_word(sel_word),
        .clear_req(clear_req), .pick_count(pick_count), .bad_pick(bad_pick),
        .miss(miss), .score(score), .all_clear(all_clear)
    );

    always #5 clk = ~clk;

    task automatic pick(input logic [3:0] c);
        @(posedge clk); #1;
        sel_card = c;
        sel_go   = 1'b1;
        @(posedge clk); #1;
        sel_go   = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 clear_done = 1'b1;
        @(posedge clk); #1 clear_done = 1'b0;
    endtask

    task automatic test_reset();
        card_syms = GAME1;
        do_reset();
        n_cmp++; if (sel_word !== 12'h000) begin n_bad++; $display("FAIL reset_sel_word: got %h want 000", sel_word); end
        n_cmp++; if (clear_req !== 1'b0) begin n_bad++; $display("FAIL reset_clear_req: got %b want 0", clear_req); end
        n_cmp++; if (pick_count !== 2'd0) begin n_bad++; $display("FAIL reset_pick_count: got %0d want 0", pick_count); end
        n_cmp++; if (bad_pick !== 1'b0) begin n_bad++; $display("FAIL reset_bad_pick: got %b want 0", bad_pick); end
        n_cmp++; if (miss !== 1'b0) begin n_bad++; $display("FAIL reset_miss: got %b want 0", miss); end
        n_cmp++; if (score !== 4'd0) begin n_bad++; $display("FAIL reset_score: got %0d want 0", score); end
        n_cmp++; if (all_clear !== 1'b0) begin n_bad++; $display("FAIL reset_all_clear: got %b want 0", all_clear); end
    endtask

    task automatic test_match();
        pulse_done();
        n_cmp++; if (score !== 4'd0) begin n_bad++; $display("FAIL done_idle_score: got %0d want 0", score); end
        pick(4'd1);
        n_cmp++; if (pick_count !== 2'd1 || sel_word !== 12'h001) begin n_bad++; $display("FAIL match_pick1: got %0d/%h want 1/001", pick_count, sel_word); end
        pick(4'd5);
        pick(4'd9);
        exp_q.push_back(12'h951);
        n_cmp++; if (pick_count !== 2'd3 || clear_req !== 1'b0) begin n_bad++; $display("FAIL match_check_cycle: got cnt %0d req %b want 3/0", pick_count, clear_req); end
        @(posedge clk); #1;
        n_cmp++; if (clear_req !== 1'b1) begin n_bad++; $display("FAIL match_latency: got %b want 1", clear_req); end
        exp_w = exp_q.pop_front();
        n_cmp++; if (sel_word !== exp_w) begin n_bad++; $display("FAIL match_sel_word: got %h want %h", sel_word, exp_w); end
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (clear_req !== 1'b1 || sel_word !== 12'h951) begin n_bad++; $display("FAIL match_hold: got %b/%h want 1/951", clear_req, sel_word); end
        pulse_done();
        n_cmp++; if (score !== 4'd1) begin n_bad++; $display("FAIL match_score: got %0d want 1", score); end
        n_cmp++; if (sel_word !== 12'h000 || pick_count !== 2'd0 || clear_req !== 1'b0) begin n_bad++; $display("FAIL match_after_done: got %h/%0d/%b want 000/0/0", sel_word, pick_count, clear_req); end
    endtask

    task automatic test_miss();
        int hi;
        hi = 0;
        pick(4'd2);
        pick(4'd3);
        pick(4'd4);
        n_cmp++; if (miss !== 1'b0 || pick_count !== 2'd3) begin n_bad++; $display("FAIL miss_check_cycle: got miss %b cnt %0d want 0/3", miss, pick_count); end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (miss) hi++;
        end
        n_cmp++; if (hi !== 4) begin n_bad++; $display("FAIL miss_length: got %0d want 4", hi); end
        n_cmp++; if (pick_count !== 2'd0 || sel_word !== 12'h000) begin n_bad++; $display("FAIL miss_release: got %0d/%h want 0/000", pick_count, sel_word); end
        n_cmp++; if (score !== 4'd1) begin n_bad++; $display("FAIL miss_score: got %0d want 1", score); end
    endtask

    task automatic test_bad_pick();
        pick(4'd0);
        n_cmp++; if (bad_pick !== 1'b1 || pick_count !== 2'd0) begin n_bad++; $display("FAIL bad_zero: got %b/%0d want 1/0", bad_pick, pick_count); end
        pick(4'd10);
        n_cmp++; if (bad_pick !== 1'b1 || pick_count !== 2'd0) begin n_bad++; $display("FAIL bad_ten: got %b/%0d want 1/0", bad_pick, pick_count); end
        pick(4'd2);
        n_cmp++; if (bad_pick !== 1'b0 || pick_count !== 2'd1) begin n_bad++; $display("FAIL bad_good_pick: got %b/%0d want 0/1", bad_pick, pick_count); end
        pick(4'd2);
        n_cmp++; if (bad_pick !== 1'b1 || pick_count !== 2'd1) begin n_bad++; $display("FAIL bad_repeat: got %b/%0d want 1/1", bad_pick, pick_count); end
        pick(4'd5);
        n_cmp++; if (bad_pick !== 1'b1 || pick_count !== 2'd1) begin n_bad++; $display("FAIL bad_removed: got %b/%0d want 1/1", bad_pick, pick_count); end
        @(posedge clk); #1;
        n_cmp++; if (bad_pick !== 1'b0) begin n_bad++; $display("FAIL bad_pulse_width: got %b want 0", bad_pick); end
        pick(4'd3);
        pick(4'd6);
        for (int i = 0; i < 20 && pick_count != 2'd0; i++) begin
            @(posedge clk); #1;
        end
        n_cmp++; if (pick_count !== 2'd0) begin n_bad++; $display("FAIL bad_recover: got %0d want 0", pick_count); end
    endtask

    task automatic test_all_clear();
        card_syms = GAME2;
        do_reset();
        @(posedge clk); #1;
        sel_card = 4'd2;
        sel_go   = 1'b1;
        repeat (20) @(posedge clk);
        #1 sel_go = 1'b0;
        n_cmp++; if (pick_count !== 2'd1 || sel_word !== 12'h002) begin n_bad++; $display("FAIL held_key: got %0d/%h want 1/002", pick_count, sel_word); end
        pick(4'd6);
        pick(4'd7);
        exp_q.push_back(12'h762);
        for (int i = 0; i < 8 && !clear_req; i++) begin
            @(posedge clk); #1;
        end
        n_cmp++; if (clear_req !== 1'b1) begin n_bad++; $display("FAIL clear1_timeout: got %b want 1", clear_req); end
        exp_w = exp_q.pop_front();
        n_cmp++; if (sel_word !== exp_w) begin n_bad++; $display("FAIL clear1_sel_word: got %h want %h", sel_word, exp_w); end
        pick(4'd3);
        pick(4'd4);
        pick(4'd8);
        n_cmp++; if (sel_word !== 12'h762 || pick_count !== 2'd3 || bad_pick !== 1'b0) begin n_bad++; $display("FAIL clear_ignores_picks: got %h/%0d/%b want 762/3/0", sel_word, pick_count, bad_pick); end
        pulse_done();
        n_cmp++; if (score !== 4'd1) begin n_bad++; $display("FAIL clear1_score: got %0d want 1", score); end
        clear_done = 1'b1;
        pick(4'd3);
        pick(4'd4);
        pick(4'd8);
        exp_q.push_back(12'h843);
        n_cmp++; if (score !== 4'd1 || clear_req !== 1'b0) begin n_bad++; $display("FAIL done_early_ignored: got %0d/%b want 1/0", score, clear_req); end
        @(posedge clk); #1;
        exp_w = exp_q.pop_front();
        n_cmp++; if (clear_req !== 1'b1 || sel_word !== exp_w) begin n_bad++; $display("FAIL clear2_entry: got %b/%h want 1/%h", clear_req, sel_word, exp_w); end
        @(posedge clk); #1;
        n_cmp++; if (clear_req !== 1'b0 || score !== 4'd2) begin n_bad++; $display("FAIL clear2_first_cycle: got %b/%0d want 0/2", clear_req, score); end
        clear_done = 1'b0;
        pick(4'd1);
        pick(4'd5);
        pick(4'd9);
        exp_q.push_back(12'h951);
        for (int i = 0; i < 8 && !clear_req; i++) begin
            @(posedge clk); #1;
        end
        exp_w = exp_q.pop_front();
        n_cmp++; if (clear_req !== 1'b1 || sel_word !== exp_w) begin n_bad++; $display("FAIL clear3_req: got %b/%h want 1/%h", clear_req, sel_word, exp_w); end
        n_cmp++; if (all_clear !== 1'b0) begin n_bad++; $display("FAIL all_clear_early: got %b want 0", all_clear); end
        pulse_done();
        n_cmp++; if (score !== 4'd3 || all_clear !== 1'b1) begin n_bad++; $display("FAIL all_clear_set: got %0d/%b want 3/1", score, all_clear); end
        pick(4'd2);
        n_cmp++; if (pick_count !== 2'd0 || bad_pick !== 1'b0 || sel_word !== 12'h000) begin n_bad++; $display("FAIL pick_after_all_clear: got %0d/%b/%h want 0/0/000", pick_count, bad_pick, sel_word); end
    endtask

    task automatic test_reset_mid_clear();
        card_syms = GAME2;
        do_reset();
        pick(4'd2);
        pick(4'd6);
        pick(4'd7);
        @(posedge clk); #1;
        n_cmp++; if (clear_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_setup: got %b want 1", clear_req); end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        n_cmp++; if (clear_req !== 1'b0 || sel_word !== 12'h000 || pick_count !== 2'd0) begin n_bad++; $display("FAIL rst_mid_outputs: got %b/%h/%0d want 0/000/0", clear_req, sel_word, pick_count); end
        n_cmp++; if (score !== 4'd0 || miss !== 1'b0 || bad_pick !== 1'b0 || all_clear !== 1'b0) begin n_bad++; $display("FAIL rst_mid_status: got %0d/%b/%b/%b want 0/0/0/0", score, miss, bad_pick, all_clear); end
        pick(4'd2);
        n_cmp++; if (pick_count !== 2'd1 || sel_word !== 12'h002) begin n_bad++; $display("FAIL rst_mid_repick: got %0d/%h want 1/002", pick_count, sel_word); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_miss();
        test_bad_pick();
        test_all_clear();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
